// File: rtl/eva_regs_pkg.sv
// eva_regs_pkg: shared types and constants for the EVA AHB register block.
// Word offsets, bus enums, FSM states and the CTRL bit index.
package eva_regs_pkg;

  localparam logic [2:0] REG_ID      = 3'd0;
  localparam logic [2:0] REG_SCRATCH = 3'd1;
  localparam logic [2:0] REG_CTRL    = 3'd2;
  localparam logic [2:0] REG_LOAD    = 3'd3;
  localparam logic [2:0] REG_CNT     = 3'd4;
  localparam logic [2:0] REG_RAW     = 3'd5;
  localparam logic [2:0] REG_MASK    = 3'd6;
  localparam logic [2:0] REG_STAT    = 3'd7;

  localparam int CTRL_EN_BIT = 0;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'd0,
    HRESP_ERROR = 2'd1
  } hresp_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_ERR1,
    S_ERR2
  } state_t;

endpackage

// File: rtl/eva_regs_timer.sv
// eva_regs_timer: reloadable down-counter, expires once per LOAD+1
// enabled cycles; a direct load overrides counting.
module eva_regs_timer
  import eva_regs_pkg::*;
(
  input  logic        hclk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] load,
  input  logic        load_wr,
  output logic [31:0] cnt,
  output logic        expire
);

  assign expire = en && (cnt == 32'd0);

  // Count down while enabled, reload on expiry or direct load.
  always_ff @(posedge hclk) begin
    if (!rst_n) begin
      cnt <= 32'd0;
    end else if (load_wr) begin
      cnt <= load;
    end else if (en) begin
      cnt <= (cnt == 32'd0) ? load : cnt - 32'd1;
    end
  end

endmodule

// File: rtl/eva_ahb_regs.sv
// eva_ahb_regs: AHB-Lite register slave with timer and interrupt unit.
// Define EVA_REGS_RD_WAIT_EN to add one wait state to every good read.
module eva_ahb_regs
  import eva_regs_pkg::*;
#(
  parameter logic [31:0] ID_VAL = 32'hEFA0_0001
) (
  input  logic        hclk,
  input  logic        rst_n,
  input  logic        hsel,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [31:0] haddr,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready_in,
  output logic        hready_out,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata,
  input  logic [31:0] irq_src,
  output logic [31:0] interrupt
);

  state_t      state;
  hresp_t      resp_q;
  logic        d_write;
  logic [2:0]  d_off;
  logic        accept;
  logic        err;
  logic        wr_en;
  logic        ctrl_en;
  logic [31:0] scratch;
  logic [31:0] load_q;
  logic [31:0] mask_q;
  logic [31:0] raw_q;
  logic [31:0] irq_q;
  logic [31:0] irq_set;
  logic [31:0] irq_clr;
  logic [31:0] cnt;
  logic [31:0] rd_mux;
  logic        load_wr;
  logic        expire;
  logic        unused_bits;

  assign unused_bits = ^{haddr[31:8], irq_src[0]};

  assign accept = hsel && hready_in &&
                  (htrans_t'(htrans) == HTRANS_NONSEQ ||
                   htrans_t'(htrans) == HTRANS_SEQ);

  assign err = (hsize != HSIZE_WORD) ||
               (haddr[1:0] != 2'b00) ||
               (haddr[7:5] != 3'b000);

  // Bus FSM: latches the address phase and registers ready/response.
  always_ff @(posedge hclk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      hready_out <= 1'b1;
      resp_q     <= HRESP_OKAY;
      d_write    <= 1'b0;
      d_off      <= 3'd0;
    end else begin
      unique case (state)
        S_WAIT: begin
          state      <= S_ACCESS;
          hready_out <= 1'b1;
          resp_q     <= HRESP_OKAY;
        end
        S_ERR1: begin
          state      <= S_ERR2;
          hready_out <= 1'b1;
          resp_q     <= HRESP_ERROR;
        end
        default: begin
          hready_out <= 1'b1;
          resp_q     <= HRESP_OKAY;
          if (accept) begin
            d_write <= hwrite;
            d_off   <= haddr[4:2];
            if (err) begin
              state      <= S_ERR1;
              hready_out <= 1'b0;
              resp_q     <= HRESP_ERROR;
            end
`ifdef EVA_REGS_RD_WAIT_EN
            else if (!hwrite) begin
              state      <= S_WAIT;
              hready_out <= 1'b0;
            end
`endif
            else begin
              state <= S_ACCESS;
            end
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign hresp   = resp_q;
  assign wr_en   = (state == S_ACCESS) && d_write;
  assign load_wr = wr_en && (d_off == REG_LOAD);
  assign irq_clr = (wr_en && d_off == REG_RAW) ? hwdata : 32'd0;
  assign irq_set = {irq_src[31:1] & ~irq_q[31:1], expire};

  // Writable register bank, updated in the write data phase.
  always_ff @(posedge hclk) begin
    if (!rst_n) begin
      scratch <= 32'd0;
      ctrl_en <= 1'b0;
      load_q  <= 32'd0;
      mask_q  <= 32'd0;
    end else if (wr_en) begin
      case (d_off)
        REG_SCRATCH: scratch <= hwdata;
        REG_CTRL:    ctrl_en <= hwdata[CTRL_EN_BIT];
        REG_LOAD:    load_q  <= hwdata;
        REG_MASK:    mask_q  <= hwdata;
        default:     ;
      endcase
    end
  end

  // Interrupt raw bits: edge/expiry set beats a same-cycle W1C clear.
  always_ff @(posedge hclk) begin
    if (!rst_n) begin
      irq_q <= 32'd0;
      raw_q <= 32'd0;
    end else begin
      irq_q <= irq_src;
      raw_q <= (raw_q & ~irq_clr) | irq_set;
    end
  end

  eva_regs_timer u_timer (
    .hclk    (hclk),
    .rst_n   (rst_n),
    .en      (ctrl_en),
    .load    (load_wr ? hwdata : load_q),
    .load_wr (load_wr),
    .cnt     (cnt),
    .expire  (expire)
  );

  // Read mux from the latched offset.
  always_comb begin
    rd_mux = 32'd0;
    case (d_off)
      REG_ID:      rd_mux = ID_VAL;
      REG_SCRATCH: rd_mux = scratch;
      REG_CTRL:    rd_mux = {31'd0, ctrl_en};
      REG_LOAD:    rd_mux = load_q;
      REG_CNT:     rd_mux = cnt;
      REG_RAW:     rd_mux = raw_q;
      REG_MASK:    rd_mux = mask_q;
      REG_STAT:    rd_mux = raw_q & mask_q;
      default:     rd_mux = 32'd0;
    endcase
  end

  assign hrdata = (state == S_ACCESS || state == S_WAIT) ? rd_mux : 32'd0;

  assign interrupt = raw_q & mask_q;

endmodule

// File: tb/tb_eva_ahb_regs.sv
// tb_eva_ahb_regs: vector-table bench for eva_ahb_regs.
// Pipelined AHB driver plus timer, interrupt and reset sequences.
module tb_eva_ahb_regs;

  localparam logic [31:0] ID = 32'hEFA0_0001;
`ifdef EVA_REGS_RD_WAIT_EN
  localparam int RDW = 1;
`else
  localparam int RDW = 0;
`endif

  logic        hclk = 1'b0;
  logic        rst_n;
  logic        hsel;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] haddr;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready_in;
  logic        hready_out;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic [31:0] irq_src;
  logic [31:0] interrupt;

  int checks = 0;
  int errors = 0;

  assign hready_in = hready_out;

  always #5 hclk = ~hclk;

  eva_ahb_regs dut (
    .hclk       (hclk),
    .rst_n      (rst_n),
    .hsel       (hsel),
    .htrans     (htrans),
    .hwrite     (hwrite),
    .haddr      (haddr),
    .hsize      (hsize),
    .hwdata     (hwdata),
    .hready_in  (hready_in),
    .hready_out (hready_out),
    .hresp      (hresp),
    .hrdata     (hrdata),
    .irq_src    (irq_src),
    .interrupt  (interrupt)
  );

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          waits;
    logic [1:0]  resp;
    logic [31:0] rdata;
    bit          chk_rd;
    bit          chk_bus;
    string       name;
  } vec_t;

  vec_t pend;
  vec_t tbl[$];

  function automatic vec_t mk(logic s, logic [1:0] t, logic w,
                              logic [31:0] a, logic [2:0] z,
                              logic [31:0] d, int wt, logic [1:0] r,
                              logic [31:0] rd, bit c, string n);
    vec_t v;
    v.sel = s; v.trans = t; v.wr = w; v.addr = a; v.size = z;
    v.wdata = d; v.waits = wt; v.resp = r; v.rdata = rd;
    v.chk_rd = c; v.chk_bus = 1'b1; v.name = n;
    return v;
  endfunction

  function automatic vec_t wr(logic [31:0] a, logic [31:0] d, string n);
    return mk(1, 2, 1, a, 3'd2, d, 0, 0, 0, 0, n);
  endfunction

  function automatic vec_t rd(logic [31:0] a, logic [31:0] e, string n);
    return mk(1, 2, 0, a, 3'd2, 0, RDW, 0, e, 1, n);
  endfunction

  function automatic vec_t idle();
    return mk(1, 0, 0, 32'h0, 3'd2, 0, 0, 0, 0, 0, "idle");
  endfunction

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", n, act, exp);
    end
  endtask

  // Drive v's address phase while pend is in its data phase.
  task automatic run(input vec_t v);
    int  waits;
    bit  done;
    waits = 0;
    done  = 1'b0;
    hsel = v.sel; htrans = v.trans; hwrite = v.wr;
    haddr = v.addr; hsize = v.size; hwdata = pend.wdata;
    for (int k = 0; k < 8 && !done; k++) begin
      if (hready_out) begin
        if (pend.chk_bus) begin
          chk({pend.name, "_waits"}, waits, pend.waits);
          chk({pend.name, "_resp"}, {30'd0, hresp}, {30'd0, pend.resp});
          if (pend.chk_rd)
            chk({pend.name, "_rdata"}, hrdata, pend.rdata);
        end
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge hclk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=%0d required=done", pend.name, waits);
    end
    pend = v;
  endtask

  initial begin
    int rise;
    pend = idle();
    pend.chk_bus = 1'b0;
    rst_n = 1'b0;
    hsel = 0; htrans = 0; hwrite = 0; haddr = 0; hsize = 3'd2;
    hwdata = 0; irq_src = 0;
    repeat (3) @(posedge hclk);
    #1;
    rst_n = 1'b1;

    chk("rst_hready", {31'd0, hready_out}, 32'd1);
    chk("rst_hresp", {30'd0, hresp}, 32'd0);
    chk("rst_hrdata", hrdata, 32'd0);
    chk("rst_interrupt", interrupt, 32'd0);

    tbl.push_back(mk(1, 0, 0, 32'h04, 3'd2, 0, 0, 0, 0, 1, "idle_rd"));
    tbl.push_back(wr(32'h04, 32'hDEADBEEF, "wr_scratch"));
    tbl.push_back(rd(32'h04, 32'hDEADBEEF, "rd_scratch"));
    tbl.push_back(rd(32'h00, ID, "rd_id"));
    tbl.push_back(mk(1, 2, 1, 32'h22, 3'd2, 32'h12345678, 1, 1, 0, 0,
                     "wr_misalign"));
    tbl.push_back(rd(32'h04, 32'hDEADBEEF, "rd_after_err"));
    tbl.push_back(mk(1, 2, 0, 32'h40, 3'd2, 0, 1, 1, 0, 0, "rd_range"));
    tbl.push_back(mk(1, 3, 1, 32'h04, 3'd1, 32'h11111111, 1, 1, 0, 0,
                     "wr_halfword"));
    tbl.push_back(rd(32'h04, 32'hDEADBEEF, "rd_after_size"));
    tbl.push_back(wr(32'h08, 32'hFFFFFFFE, "wr_ctrl"));
    tbl.push_back(rd(32'h08, 32'h0, "rd_ctrl"));
    tbl.push_back(wr(32'h00, 32'h0, "wr_id"));
    tbl.push_back(rd(32'h00, ID, "rd_id_ro"));
    tbl.push_back(mk(1, 1, 1, 32'h04, 3'd2, 32'h0, 0, 0, 0, 0, "busy"));
    tbl.push_back(mk(0, 2, 1, 32'h04, 3'd2, 32'h0, 0, 0, 0, 0, "nosel"));
    tbl.push_back(rd(32'h04, 32'hDEADBEEF, "rd_after_busy"));
    tbl.push_back(wr(32'h18, 32'hA5A5A5A4, "wr_mask"));
    tbl.push_back(rd(32'h18, 32'hA5A5A5A4, "rd_mask"));
    tbl.push_back(wr(32'h18, 32'h0, "wr_mask0"));
    tbl.push_back(rd(32'h1C, 32'h0, "rd_stat0"));
    tbl.push_back(wr(32'h0C, 32'h55, "wr_load"));
    tbl.push_back(rd(32'h0C, 32'h55, "rd_load"));
    tbl.push_back(rd(32'h10, 32'h55, "rd_cnt"));
    tbl.push_back(rd(32'h14, 32'h0, "rd_raw0"));
    tbl.push_back(idle());

    foreach (tbl[i]) run(tbl[i]);

    // Timer: LOAD=3 expires on the 4th enabled cycle.
    run(wr(32'h0C, 32'd3, "t_load"));
    run(wr(32'h18, 32'd1, "t_mask"));
    run(wr(32'h08, 32'd1, "t_en"));
    run(idle());
    chk("timer_pre", interrupt, 32'd0);
    rise = 0;
    for (int k = 1; k <= 10 && rise == 0; k++) begin
      @(posedge hclk);
      #1;
      if (interrupt[0]) rise = k;
    end
    chk("timer_rise", rise, 4);

    run(wr(32'h08, 32'd0, "t_stop"));
    run(wr(32'h14, 32'd1, "t_w1c"));
    run(idle());
    chk("w1c_clear", interrupt, 32'd0);

    // Expiry every cycle so the W1C collides with a set.
    run(wr(32'h0C, 32'd0, "c_load"));
    run(wr(32'h08, 32'd1, "c_en"));
    run(wr(32'h14, 32'd1, "c_w1c"));
    run(idle());
    chk("set_wins", {31'd0, interrupt[0]}, 32'd1);
    run(wr(32'h08, 32'd0, "c_stop"));
    run(wr(32'h14, 32'd1, "c_w1c2"));
    run(idle());
    chk("clear_after_stop", interrupt, 32'd0);

    // Source edge on irq_src[5].
    run(wr(32'h18, 32'd0, "s_mask0"));
    run(idle());
    irq_src[5] = 1'b1;
    @(posedge hclk);
    #1;
    chk("src_masked", interrupt, 32'd0);
    run(rd(32'h14, 32'h20, "s_raw"));
    run(wr(32'h18, 32'h20, "s_mask"));
    run(idle());
    chk("src_int", interrupt, 32'h20);
    run(rd(32'h1C, 32'h20, "s_stat"));
    run(wr(32'h14, 32'h20, "s_w1c"));
    run(rd(32'h14, 32'h0, "s_raw_clr"));
    run(idle());

    // Reset during the data phase of a SCRATCH write.
    run(wr(32'h04, 32'h12345678, "r_wr"));
    hwdata = 32'h12345678;
    hsel = 0; htrans = 0;
    rst_n = 1'b0;
    @(posedge hclk);
    #1;
    chk("rstmid_hready", {31'd0, hready_out}, 32'd1);
    chk("rstmid_hresp", {30'd0, hresp}, 32'd0);
    chk("rstmid_hrdata", hrdata, 32'd0);
    chk("rstmid_interrupt", interrupt, 32'd0);
    rst_n = 1'b1;
    pend = idle();
    pend.chk_bus = 1'b0;
    run(rd(32'h04, 32'h0, "r_scratch"));
    run(rd(32'h14, 32'h20, "r_raw_hi"));
    run(idle());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
